mem_bus_arbiter: RTL and testbench

//  Shares one external memory bus between instruction fetch (PC/IF stage) and data access (MEM stage).

---
 rtl/mem_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one external bus between instruction fetch and
// data access. Data has fixed priority over fetch. One transaction is in
// flight at a time, and an ack watchdog aborts a transaction whose ack never
// arrives. Port names follow the pipeline/bus naming used by the integrating
// core, so they carry no direction suffix.
module mem_bus_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 255   // 1..255
) (
  input  logic        clk,
  input  logic        rst,          // synchronous, active-low
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  // pipeline redirect
  input  logic        flush,
  // external bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  // stall requests
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  typedef enum logic [1:0] {IDLE, D_BUSY, IF_BUSY} state_e;

  localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        drop_q, drop_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        if_err_q, if_err_d;
  logic        d_valid_q, d_valid_d;
  logic        d_err_q, d_err_d;

  logic        d_pend, if_pend, tmo, done, drop_now;
  logic [7:0]  wdog_inc;

  // A port that just got its valid must not be re-issued in the same cycle.
  assign d_pend   = d_req & ~d_valid_q;
  assign if_pend  = if_req & ~if_valid_q & ~flush;
  // wdog_inc counts bus_req cycles including the current one.
  assign wdog_inc = wdog_q + 8'd1;
  assign tmo      = (wdog_inc == TMO);
  assign done     = (state_q != IDLE) & (bus_ack | tmo);
  // A flush coinciding with the ack still discards the fetch result.
  assign drop_now = drop_q | flush;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: data wins over fetch; busy states leave on ack or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_pend)       state_d = D_BUSY;
        else if (if_pend) state_d = IF_BUSY;
      end
      D_BUSY, IF_BUSY: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: bus fields load on issue, results on completion
  always_comb begin
    wdog_d      = 8'd0;
    drop_d      = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    d_valid_d   = 1'b0;
    d_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend) begin
          bus_req_d   = 1'b1;
          bus_we_d    = d_we;
          bus_sel_d   = d_sel;
          bus_addr_d  = d_addr;
          bus_wdata_d = d_wdata;
        end else if (if_pend) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'hF;
          bus_addr_d  = if_addr;
        end
      end
      D_BUSY: begin
        wdog_d = wdog_inc;
        if (done) begin
          wdog_d    = 8'd0;
          bus_req_d = 1'b0;
          d_valid_d = 1'b1;
          d_err_d   = ~bus_ack;
          d_rdata_d = bus_ack ? bus_rdata : 32'd0;
        end
      end
      IF_BUSY: begin
        wdog_d = wdog_inc;
        drop_d = drop_now;
        if (done) begin
          wdog_d    = 8'd0;
          drop_d    = 1'b0;
          bus_req_d = 1'b0;
          if (!drop_now) begin
            if_valid_d = 1'b1;
            if_err_d   = ~bus_ack;
            if_rdata_d = bus_ack ? bus_rdata : 32'd0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset also aborts a transaction in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q      <= 8'd0;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'd0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;

  assign stallreq_if  = if_req & ~if_valid_q & ~flush;
  assign stallreq_mem = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus issues
// and expected port responses; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_err;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid, d_err;
  logic        flush = 1'b0;
  logic        bus_req, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        stallreq_if, stallreq_mem;

  mem_bus_arbiter #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        port;   // 0 fetch, 1 data
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] cyc;
  } bus_t;

  rsp_t rq[$];
  bus_t bq[$];
  int   checks = 0;
  int   failures = 0;
  logic breq_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pb(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                    input logic [31:0] wdata, input int c);
    bus_t b;
    b.we = we; b.sel = sel; b.addr = addr; b.wdata = wdata; b.cyc = 32'(c);
    bq.push_back(b);
  endtask

  task automatic pr(input logic port, input logic err, input logic [31:0] rdata, input int c);
    rsp_t r;
    r.port = port; r.err = err; r.rdata = rdata; r.cyc = 32'(c);
    rq.push_back(r);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every response pulse and every new bus issue
  always @(negedge clk) begin
    if (rst) begin
      chk("stray_err", {30'd0, if_err & ~if_valid, d_err & ~d_valid}, 32'd0);
      if (if_valid || d_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_valid", {30'd0, if_valid, d_valid}, 32'd0);
        end else begin
          rsp_t e;
          e = rq.pop_front();
          chk("rsp_port", {30'd0, if_valid, d_valid}, e.port ? 32'd1 : 32'd2);
          chk("rsp_err", {31'd0, e.port ? d_err : if_err}, {31'd0, e.err});
          chk("rsp_rdata", e.port ? d_rdata : if_rdata, e.rdata);
          chk("rsp_cycle", 32'(cyc), e.cyc);
        end
      end
      if (bus_req && !breq_prev) begin
        if (bq.size() == 0) begin
          chk("unexpected_bus_req", {31'd0, bus_req}, 32'd0);
        end else begin
          bus_t b;
          b = bq.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_we", {31'd0, bus_we}, {31'd0, b.we});
          chk("bus_sel", {28'd0, bus_sel}, {28'd0, b.sel});
          if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
          chk("bus_cycle", 32'(cyc), b.cyc);
        end
      end
    end
    breq_prev = bus_req;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int n;
    // Reset state
    repeat (3) tick;
    @(negedge clk);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_fields", {27'd0, bus_we, bus_sel}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_pulses", {28'd0, if_valid, if_err, d_valid, d_err}, 32'd0);
    tick; rst = 1'b1;
    tick; tick;

    // T1: single fetch, ack in first bus_req cycle
    c0 = cyc; if_req = 1'b1; if_addr = 32'hBFC00000;
    pb(1'b0, 4'hF, 32'hBFC00000, 32'd0, c0 + 1);
    pr(1'b0, 1'b0, 32'h3C08BFC0, c0 + 2);
    @(negedge clk); chk("t1_stall_c0", {31'd0, stallreq_if}, 32'd1);
    tick; bus_ack = 1'b1; bus_rdata = 32'h3C08BFC0;
    @(negedge clk); chk("t1_stall_c1", {31'd0, stallreq_if}, 32'd1);
    tick; bus_ack = 1'b0;
    @(negedge clk); chk("t1_stall_c2", {31'd0, stallreq_if}, 32'd0);
    tick; if_req = 1'b0;
    tick;

    // T2: fetch and store together; store first, fetch issues in d_valid cycle.
    // Flush during D_BUSY must not disturb the data access.
    c0 = cyc; if_req = 1'b1; if_addr = 32'hBFC00004;
    d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_addr = 32'h80000010; d_wdata = 32'h12345678;
    pb(1'b1, 4'b0011, 32'h80000010, 32'h12345678, c0 + 1);
    pr(1'b1, 1'b0, 32'hCAFE0001, c0 + 2);
    pb(1'b0, 4'hF, 32'hBFC00004, 32'd0, c0 + 3);
    pr(1'b0, 1'b0, 32'h24020001, c0 + 4);
    @(negedge clk); chk("t2_stall_mem_c0", {31'd0, stallreq_mem}, 32'd1);
    tick; bus_ack = 1'b1; bus_rdata = 32'hCAFE0001; flush = 1'b1;
    @(negedge clk); chk("t2_stall_if_flush", {31'd0, stallreq_if}, 32'd0);
    tick; bus_ack = 1'b0; flush = 1'b0;
    @(negedge clk); chk("t2_stall_mem_c2", {31'd0, stallreq_mem}, 32'd0);
    tick; d_req = 1'b0; d_we = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h24020001;
    tick; bus_ack = 1'b0;
    tick; if_req = 1'b0;
    tick;

    // T3: flush two cycles into a fetch; result dropped, new pc fetched next
    c0 = cyc; if_req = 1'b1; if_addr = 32'hBFC00100;
    pb(1'b0, 4'hF, 32'hBFC00100, 32'd0, c0 + 1);
    tick;
    tick; flush = 1'b1; if_addr = 32'hBFC00380;
    @(negedge clk); chk("t3_stall_flush", {31'd0, stallreq_if}, 32'd0);
    tick; flush = 1'b0;
    tick; bus_ack = 1'b1; bus_rdata = 32'hDEAD0000;
    tick; bus_ack = 1'b0;
    pb(1'b0, 4'hF, 32'hBFC00380, 32'd0, c0 + 6);
    pr(1'b0, 1'b0, 32'h8C040000, c0 + 7);
    @(negedge clk); chk("t3_no_if_valid", {31'd0, if_valid}, 32'd0);
    tick; bus_ack = 1'b1; bus_rdata = 32'h8C040000;
    tick; bus_ack = 1'b0;
    tick; if_req = 1'b0;
    tick;

    // T4: no ack -> bus_req for exactly ACK_TIMEOUT cycles, then error
    c0 = cyc; d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h80001000;
    bus_rdata = 32'hFFFFFFFF;
    pb(1'b0, 4'hF, 32'h80001000, 32'd0, c0 + 1);
    pr(1'b1, 1'b1, 32'd0, c0 + 5);
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      @(negedge clk);
      if (bus_req) n++;
    end
    chk("t4_req_cycles", 32'(n), 32'd4);
    tick; d_req = 1'b0;
    tick;

    // T5: reset during D_BUSY, late ack must be ignored
    c0 = cyc; d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF; d_addr = 32'h80002000;
    d_wdata = 32'hA5A5A5A5;
    pb(1'b1, 4'hF, 32'h80002000, 32'hA5A5A5A5, c0 + 1);
    tick;
    tick; rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); chk("t5_req_before_edge", {31'd0, bus_req}, 32'd1);
    tick; rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5555AAAA;
    @(negedge clk); chk("t5_req_after_rst", {31'd0, bus_req}, 32'd0);
    chk("t5_no_dvalid_c3", {31'd0, d_valid}, 32'd0);
    tick; bus_ack = 1'b0;
    @(negedge clk); chk("t5_no_dvalid_c4", {30'd0, d_valid, bus_req}, 32'd0);
    tick;

    // T6: back-to-back loads with d_req held high throughout
    d_req = 1'b1; d_we = 1'b0; d_sel = 4'hF;
    for (int k = 0; k < 3; k++) begin
      c0 = cyc; d_addr = 32'h80003000 + 32'(k * 4);
      pb(1'b0, 4'hF, 32'h80003000 + 32'(k * 4), 32'd0, c0 + 1);
      pr(1'b1, 1'b0, 32'h11110000 + 32'(k), c0 + 2);
      tick; bus_ack = 1'b1; bus_rdata = 32'h11110000 + 32'(k);
      tick; bus_ack = 1'b0;
      tick;
    end
    d_req = 1'b0;
    tick;

    // T7: flush in IDLE holds off a fetch for that cycle
    c0 = cyc; if_req = 1'b1; if_addr = 32'hBFC00400; flush = 1'b1;
    @(negedge clk); chk("t7_stall_flush", {31'd0, stallreq_if}, 32'd0);
    tick; flush = 1'b0;
    pb(1'b0, 4'hF, 32'hBFC00400, 32'd0, c0 + 2);
    pr(1'b0, 1'b0, 32'h1234ABCD, c0 + 3);
    tick; bus_ack = 1'b1; bus_rdata = 32'h1234ABCD;
    tick; bus_ack = 1'b0;
    tick; if_req = 1'b0;
    tick; tick;

    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    chk("bus_queue_empty", 32'(bq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
